// File: rtl/zigbee_chip_spreader.sv
// 802.15.4 O-QPSK DSSS spreader: bytes in over valid/ready, 32-chip PN sequences out
// serially (low nibble first), with chip parity driving the downstream I/Q demux.
module zigbee_chip_spreader #(
  parameter int unsigned CHIP_DIV = 1
) (
  input  logic       inClk,
  input  logic       inRst,
  input  logic [7:0] inByte,
  input  logic       inValid,
  output logic       outReady,
  output logic       outChip,
  output logic       outSel,
  output logic       outChipValid,
  output logic       outBusy
);

  typedef enum logic {
    ST_IDLE,
    ST_SPREAD
  } state_e;

  // Symbol 0 with chip c0 in the MSB; the other 15 symbols are derived from it.
  localparam logic [31:0] SYM0     = 32'b11011001110000110101001000101110;
  localparam logic [31:0] ODD_MASK = 32'h5555_5555;
  localparam logic [7:0]  DIV_LAST = 8'(CHIP_DIV - 1);

  function automatic logic [31:0] pn_word(input logic [3:0] sym);
    logic [4:0]  rot;
    logic [63:0] dbl;
    logic [31:0] w;
    rot = {sym[2:0], 2'b00};
    dbl = {SYM0, SYM0} >> rot;
    w   = dbl[31:0];
    if (sym[3]) w = w ^ ODD_MASK;
    return w;
  endfunction

  function automatic logic chip_of(input logic [7:0] b, input logic [5:0] idx);
    logic [3:0]  nib;
    logic [31:0] w;
    nib = idx[5] ? b[7:4] : b[3:0];
    w   = pn_word(nib);
    return w[5'd31 - idx[4:0]];
  endfunction

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] div_q, div_d;
  logic [5:0] idx_q, idx_d;
  logic       chip_q, chip_d;
  logic       sel_q, sel_d;
  logic       strobe_q, strobe_d;

  logic take;
  logic div_wrap;
  logic byte_end;

  assign take     = inValid && !hold_full_q;
  assign div_wrap = (div_q == DIV_LAST);
  assign byte_end = div_wrap && (idx_q == 6'd63);

  // NOTE: every signal assigned below gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    div_d       = div_q;
    idx_d       = idx_q;
    chip_d      = chip_q;
    sel_d       = sel_q;
    strobe_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        chip_d = 1'b0;
        sel_d  = 1'b0;
        div_d  = '0;
        idx_d  = '0;
        if (take) begin
          state_d  = ST_SPREAD;
          shift_d  = inByte;
          chip_d   = chip_of(inByte, 6'd0);
          strobe_d = 1'b1;
        end
      end

      ST_SPREAD: begin
        if (take) begin
          hold_d      = inByte;
          hold_full_d = 1'b1;
        end

        if (!div_wrap) begin
          div_d = div_q + 8'd1;
        end else if (!byte_end) begin
          div_d    = '0;
          idx_d    = idx_q + 6'd1;
          chip_d   = chip_of(shift_q, idx_q + 6'd1);
          sel_d    = ~sel_q;
          strobe_d = 1'b1;
        end else begin
          div_d = '0;
          idx_d = '0;
          sel_d = 1'b0;
          // A byte arriving exactly at end of byte bypasses the holding register.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            chip_d      = chip_of(hold_q, 6'd0);
            strobe_d    = 1'b1;
          end else if (take) begin
            shift_d     = inByte;
            hold_full_d = 1'b0;
            chip_d      = chip_of(inByte, 6'd0);
            strobe_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
            chip_d  = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      chip_q      <= 1'b0;
      sel_q       <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      chip_q      <= chip_d;
      sel_q       <= sel_d;
      strobe_q    <= strobe_d;
    end
  end

  // NOTE: the byte data registers carry no reset; they are only read while the
  // state and hold_full flag, which are reset, say they hold a live byte.
  always_ff @(posedge inClk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
  end

  assign outReady     = ~hold_full_q;
  assign outChip      = chip_q;
  assign outSel       = sel_q;
  assign outChipValid = strobe_q;
  assign outBusy      = (state_q == ST_SPREAD);

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Scoreboard bench for zigbee_chip_spreader: one instance at CHIP_DIV=1, one at CHIP_DIV=4,
// expected chips taken from the literal 802.15.4 chip table.
module tb_zigbee_chip_spreader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a_byte, b_byte;
  logic       a_valid, b_valid;
  logic       a_ready, a_chip, a_sel, a_cv, a_busy;
  logic       b_ready, b_chip, b_sel, b_cv, b_busy;

  zigbee_chip_spreader #(.CHIP_DIV(1)) dut_a (
    .inClk(clk), .inRst(rst), .inByte(a_byte), .inValid(a_valid),
    .outReady(a_ready), .outChip(a_chip), .outSel(a_sel),
    .outChipValid(a_cv), .outBusy(a_busy)
  );

  zigbee_chip_spreader #(.CHIP_DIV(4)) dut_b (
    .inClk(clk), .inRst(rst), .inByte(b_byte), .inValid(b_valid),
    .outReady(b_ready), .outChip(b_chip), .outSel(b_sel),
    .outChipValid(b_cv), .outBusy(b_busy)
  );

  logic [31:0] golden [16] = '{
    32'b11011001110000110101001000101110,
    32'b11101101100111000011010100100010,
    32'b00101110110110011100001101010010,
    32'b00100010111011011001110000110101,
    32'b01010010001011101101100111000011,
    32'b00110101001000101110110110011100,
    32'b11000011010100100010111011011001,
    32'b10011100001101010010001011101101,
    32'b10001100100101100000011101111011,
    32'b10111000110010010110000001110111,
    32'b01111011100011001001011000000111,
    32'b01110111101110001100100101100000,
    32'b00000111011110111000110010010110,
    32'b01100000011101111011100011001001,
    32'b10010110000001110111101110001100,
    32'b11001001011000000111011110111000
  };

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] qa [$];
  logic [1:0] qb [$];
  logic [1:0] pair_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pushes {chip, sel} for all 64 chips of a byte; for instance A also the I/Q pairs.
  task automatic expect_byte(input bit to_b, input logic [7:0] v);
    logic [31:0] w;
    logic        c;
    logic        prev;
    prev = 1'b0;
    for (int k = 0; k < 64; k++) begin
      w = golden[(k < 32) ? v[3:0] : v[7:4]];
      c = w[31 - (k % 32)];
      if (to_b) qb.push_back({c, 1'(k % 2)});
      else begin
        qa.push_back({c, 1'(k % 2)});
        if (k % 2 == 1) pair_q.push_back({prev, c});
      end
      prev = c;
    end
  endtask

  int   a_strobes = 0, a_first = -1, a_last = -1, a_busy_cyc = 0;
  logic demux_i = 1'b0;
  always @(negedge clk) begin
    logic [1:0] e;
    logic [1:0] p;
    if (a_busy === 1'b1) a_busy_cyc++;
    if (a_cv === 1'b1) begin
      a_strobes++;
      if (a_first < 0) a_first = cyc;
      a_last = cyc;
      e = (qa.size() > 0) ? qa.pop_front() : 2'bxx;
      check("a_chip", 32'(a_chip), 32'(e[1]));
      check("a_sel", 32'(a_sel), 32'(e[0]));
      if (a_sel === 1'b0) demux_i = a_chip;
      else begin
        p = (pair_q.size() > 0) ? pair_q.pop_front() : 2'bxx;
        check("a_iq_pair", 32'({demux_i, a_chip}), 32'(p));
      end
    end
  end

  int   b_strobes = 0, b_last = -1;
  logic b_hold = 1'b0;
  always @(negedge clk) begin
    logic [1:0] e;
    if (b_cv === 1'b1) begin
      b_strobes++;
      if (b_last >= 0) check("b_gap", 32'(cyc - b_last), 32'd4);
      b_last = cyc;
      e = (qb.size() > 0) ? qb.pop_front() : 2'bxx;
      check("b_chip", 32'(b_chip), 32'(e[1]));
      check("b_sel", 32'(b_sel), 32'(e[0]));
      b_hold = b_chip;
    end else if (b_busy === 1'b1 && b_last >= 0) begin
      check("b_stable", 32'(b_chip), 32'(b_hold));
    end
  end

  task automatic send_a(input logic [7:0] v, output int waited);
    a_byte  = v;
    a_valid = 1'b1;
    waited  = 0;
    while (a_ready !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (a_ready !== 1'b1) check("a_ready_timeout", 32'(a_ready), 32'd1);
    expect_byte(1'b0, v);
    @(negedge clk);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (a_busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("a_idle_timeout", 32'(a_busy), 32'd0);
  endtask

  initial begin
    int w1, w2, w3, acc, n, saved;
    logic [7:0] table_bytes [8];
    table_bytes = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_byte = 8'h00; b_byte = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_a_chip", 32'(a_chip), 32'd0);
    check("rst_a_sel", 32'(a_sel), 32'd0);
    check("rst_a_cv", 32'(a_cv), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    check("rst_b_cv", 32'(b_cv), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_strobe", 32'(a_strobes + b_strobes), 32'd0);

    // Byte 0x80 at CHIP_DIV=1: symbol 0 then symbol 8, 64 busy cycles.
    a_strobes = 0; a_first = -1; a_busy_cyc = 0;
    send_a(8'h80, w1);
    acc = cyc;
    a_valid = 1'b0;
    wait_idle_a();
    check("a80_latency", 32'(a_first - acc), 32'd0);
    check("a80_strobes", 32'(a_strobes), 32'd64);
    check("a80_busy_cycles", 32'(a_busy_cyc), 32'd64);
    check("a80_sb_empty", 32'(qa.size()), 32'd0);

    // Byte 0x01 at CHIP_DIV=4: 4-cycle spacing, stable chip between strobes.
    b_byte = 8'h01;
    b_valid = 1'b1;
    check("b_ready_before", 32'(b_ready), 32'd1);
    expect_byte(1'b1, 8'h01);
    @(negedge clk);
    b_valid = 1'b0;
    n = 0;
    while (b_busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("b_idle_timeout", 32'(b_busy), 32'd0);
    check("b01_strobes", 32'(b_strobes), 32'd64);
    check("b01_sb_empty", 32'(qb.size()), 32'd0);

    // Back-to-back 0x10, 0x32, 0x54 with inValid held high.
    a_strobes = 0; a_first = -1;
    send_a(8'h10, w1);
    send_a(8'h32, w2);
    send_a(8'h54, w3);
    a_valid = 1'b0;
    check("b2b_second_no_wait", 32'(w2), 32'd0);
    check("b2b_third_wait", 32'(w3), 32'd63);
    wait_idle_a();
    check("b2b_strobes", 32'(a_strobes), 32'd192);
    check("b2b_no_gap", 32'(a_last - a_first), 32'd191);
    check("b2b_sb_empty", 32'(qa.size()), 32'd0);

    // Reset at chip 20 of 0xFF while 0x00 is held.
    a_strobes = 0;
    send_a(8'hFF, w1);
    send_a(8'h00, w2);
    repeat (19) @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_cv", 32'(a_cv), 32'd0);
    check("rst_mid_ready", 32'(a_ready), 32'd1);
    check("rst_mid_busy", 32'(a_busy), 32'd0);
    check("rst_mid_chip", 32'(a_chip), 32'd0);
    saved = a_strobes;
    check("rst_mid_strobes_before", 32'(saved), 32'd21);
    qa.delete();
    pair_q.delete();
    repeat (150) @(negedge clk);
    check("rst_mid_no_more_strobes", 32'(a_strobes), 32'(saved));
    check("rst_mid_busy_after", 32'(a_busy), 32'd0);

    // Full chip table through all 16 symbols plus the I/Q pair model.
    a_strobes = 0; a_first = -1;
    for (int i = 0; i < 8; i++) send_a(table_bytes[i], w1);
    a_valid = 1'b0;
    wait_idle_a();
    check("table_strobes", 32'(a_strobes), 32'd512);
    check("table_no_gap", 32'(a_last - a_first), 32'd511);
    check("table_sb_empty", 32'(qa.size()), 32'd0);
    check("table_pairs_empty", 32'(pair_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
